// File: rtl/i2s_tx_stream.sv
// Parametrised I2S / left-justified stereo transmitter fed by a valid/ready sample-pair FIFO.
// Frame, lrck and sdin update only on the sck fall event; mute and underrun are resolved at frame load.
module i2s_tx_stream #(
   parameter int DATA_W     = 16,
   parameter int SLOT_W     = 16,
   parameter int SCK_HALF   = 8,
   parameter int MCLK_HALF  = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int MODE       = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_W-1:0]           s_left,
   input  logic [DATA_W-1:0]           s_right,
   input  logic                        mute,
   output logic                        audio_mclk,
   output logic                        audio_lrck,
   output logic                        audio_sck,
   output logic                        audio_sdin,
   output logic                        underrun,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int FW  = 2 * SLOT_W;
   localparam int BW  = $clog2(FW);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int SDW = $clog2(SCK_HALF);
   localparam int MDW = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;

   logic [MDW-1:0]      mclk_cnt_r;
   logic [SDW-1:0]      div_cnt_r;
   logic [BW-1:0]       bit_cnt_r;
   logic [FW-1:0]       frame_r;
   logic [AW-1:0]       wr_ptr_r;
   logic [AW-1:0]       rd_ptr_r;
   logic [2*DATA_W-1:0] mem_r [FIFO_DEPTH];

   logic                sck_wrap_s;
   logic                fall_s;
   logic                load_s;
   logic                empty_s;
   logic                push_s;
   logic                pop_s;
   logic [BW-1:0]       bit_next_s;
   logic [LW-1:0]       level_next_s;
   logic [2*DATA_W-1:0] pop_data_s;
   logic [SLOT_W-1:0]   slot_l_s;
   logic [SLOT_W-1:0]   slot_r_s;
   logic [FW-1:0]       frame_next_s;
   logic                sdin_next_s;

   always_comb begin
      sck_wrap_s   = (div_cnt_r == SDW'(SCK_HALF - 1));
      fall_s       = sck_wrap_s && audio_sck;
      load_s       = fall_s && (bit_cnt_r == BW'(FW - 1));
      empty_s      = (fifo_level == LW'(0));
      push_s       = s_valid && s_ready;
      pop_s        = load_s && !empty_s;
      bit_next_s   = (bit_cnt_r == BW'(FW - 1)) ? BW'(0) : bit_cnt_r + BW'(1);
      pop_data_s   = mem_r[rd_ptr_r];
      slot_l_s     = '0;
      slot_r_s     = '0;
      slot_l_s[SLOT_W-1 -: DATA_W] = pop_data_s[2*DATA_W-1 -: DATA_W];
      slot_r_s[SLOT_W-1 -: DATA_W] = pop_data_s[DATA_W-1:0];

      if (push_s && !pop_s) begin
         level_next_s = fifo_level + LW'(1);
      end else if (pop_s && !push_s) begin
         level_next_s = fifo_level - LW'(1);
      end else begin
         level_next_s = fifo_level;
      end

      // An empty FIFO at load gives a silent frame regardless of mute
      if (load_s) begin
         if (empty_s || mute) begin
            frame_next_s = '0;
         end else begin
            frame_next_s = {slot_l_s, slot_r_s};
         end
      end else begin
         frame_next_s = frame_r;
      end

      // In I2S framing bit 0 of a frame still carries the previous frame's last bit
      if (MODE == 1) begin
         sdin_next_s = frame_next_s[BW'(FW - 1) - bit_next_s];
      end else if (bit_next_s == BW'(0)) begin
         sdin_next_s = frame_r[0];
      end else begin
         sdin_next_s = frame_next_s[BW'(FW) - bit_next_s];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mclk_cnt_r <= '0;
         audio_mclk <= 1'b0;
      end else if (mclk_cnt_r == MDW'(MCLK_HALF - 1)) begin
         mclk_cnt_r <= '0;
         audio_mclk <= !audio_mclk;
      end else begin
         mclk_cnt_r <= mclk_cnt_r + MDW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_r  <= '0;
         audio_sck  <= 1'b0;
         bit_cnt_r  <= '0;
         frame_r    <= '0;
         audio_lrck <= 1'b0;
         audio_sdin <= 1'b0;
         underrun   <= 1'b0;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         fifo_level <= '0;
         s_ready    <= 1'b0;
      end else begin
         div_cnt_r <= sck_wrap_s ? SDW'(0) : div_cnt_r + SDW'(1);
         if (sck_wrap_s) begin
            audio_sck <= !audio_sck;
         end
         if (fall_s) begin
            bit_cnt_r  <= bit_next_s;
            frame_r    <= frame_next_s;
            audio_lrck <= (bit_next_s >= BW'(SLOT_W));
            audio_sdin <= sdin_next_s;
         end
         underrun <= load_s && empty_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         fifo_level <= level_next_s;
         s_ready    <= (level_next_s != LW'(FIFO_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         mem_r[wr_ptr_r] <= {s_left, s_right};
      end
   end
endmodule

// File: tb/tb_i2s_tx_stream.sv
// Bench for i2s_tx_stream: an I2S 16-bit instance and a left-justified 12-bit instance, both checked
// every clk against a frame-level model driven by cycle arithmetic and a sample-pair queue.
module tb_i2s_tx_stream;
   localparam int SH        = 8;
   localparam int MH        = 2;
   localparam int DEPTH     = 4;
   localparam int SLOT      = 16;
   localparam int FW        = 2 * SLOT;
   localparam int FRAME_CLK = 2 * FW * SH;
   localparam int RST_AT    = 8 * FRAME_CLK + 9 * 2 * SH + 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   density = 90;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int DW = (g == 0) ? 16 : 12;
      localparam int MD = (g == 0) ? 0 : 1;
      logic                    s_valid;
      logic                    s_ready;
      logic [DW-1:0]           s_left;
      logic [DW-1:0]           s_right;
      logic                    mute;
      logic                    mclk;
      logic                    lrck;
      logic                    sck;
      logic                    sdin;
      logic                    unr;
      logic [$clog2(DEPTH):0]  level;

      i2s_tx_stream #(
         .DATA_W(DW), .SLOT_W(SLOT), .SCK_HALF(SH), .MCLK_HALF(MH), .FIFO_DEPTH(DEPTH), .MODE(MD)
      ) dut (
         .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left),
         .s_right(s_right), .mute(mute), .audio_mclk(mclk), .audio_lrck(lrck), .audio_sck(sck),
         .audio_sdin(sdin), .underrun(unr), .fifo_level(level)
      );

      initial begin
         logic [2*DW-1:0] q[$];
         logic [2*DW-1:0] pair;
         logic [FW-1:0]   frame_m;
         logic [FW-1:0]   prev_m;
         int              cyc;
         int              m;
         int              b;
         bit              exp_ready;
         bit              exp_unr;
         bit              pushed;
         bit              first;
         logic            e_sdin;
         string           p;
         p         = $sformatf("u%0d", g);
         s_valid   = 1'b0;
         s_left    = '0;
         s_right   = '0;
         mute      = 1'b0;
         cyc       = 0;
         frame_m   = '0;
         prev_m    = '0;
         exp_ready = 1'b0;
         first     = 1'b1;
         forever begin
            @(posedge clk);
            pushed  = 1'b0;
            exp_unr = 1'b0;
            if (rst) begin
               q.delete();
               cyc       = 0;
               frame_m   = '0;
               prev_m    = '0;
               exp_ready = 1'b0;
            end else begin
               cyc++;
               if (cyc % FRAME_CLK == 0) begin
                  prev_m = frame_m;
                  if (q.size() == 0) begin
                     frame_m = '0;
                     exp_unr = 1'b1;
                  end else begin
                     pair    = q.pop_front();
                     frame_m = mute ? '0 : ((FW'(pair[2*DW-1:DW]) << (FW - DW)) |
                                            (FW'(pair[DW-1:0]) << (SLOT - DW)));
                  end
               end
               if (s_valid && exp_ready) begin
                  q.push_back({s_left, s_right});
                  pushed = 1'b1;
               end
               exp_ready = (q.size() < DEPTH);
            end

            @(negedge clk);
            m = cyc / (2 * SH);
            b = m % FW;
            if (MD == 1) begin
               e_sdin = frame_m[FW-1-b];
            end else if (b == 0) begin
               e_sdin = prev_m[0];
            end else begin
               e_sdin = frame_m[FW-b];
            end
            check_eq({p, ".sck"},      64'(sck),     64'((cyc / SH) % 2));
            check_eq({p, ".mclk"},     64'(mclk),    64'((cyc / MH) % 2));
            check_eq({p, ".lrck"},     64'(lrck),    64'(b >= SLOT));
            check_eq({p, ".sdin"},     64'(sdin),    64'(e_sdin));
            check_eq({p, ".underrun"}, 64'(unr),     64'(exp_unr));
            check_eq({p, ".level"},    64'(level),   64'(q.size()));
            check_eq({p, ".s_ready"},  64'(s_ready), 64'(exp_ready));

            // New data only once the previous pair was taken; near a boundary in the sparse phase force a push
            if (pushed || !s_valid) begin
               s_valid = ($urandom_range(99) < density) ||
                         (density < 10 && ((cyc + 1) % FRAME_CLK == 0));
               if (first && s_valid) begin
                  s_left  = DW'(g == 0 ? 32'hA5C3 : 32'h801);
                  s_right = DW'(g == 0 ? 32'h0F01 : $urandom);
                  first   = 1'b0;
               end else begin
                  s_left  = DW'($urandom);
                  s_right = DW'($urandom);
               end
            end
            mute = (density == 50 || density == 30) && ($urandom_range(99) < 25);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst     = 1'b0;
      density = 90;
      repeat (3 * FRAME_CLK) @(posedge clk);
      density = 2;
      repeat (3 * FRAME_CLK) @(posedge clk);
      density = 50;
      repeat (RST_AT - 6 * FRAME_CLK) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      density = 90;
      repeat (2 * FRAME_CLK) @(posedge clk);
      density = 30;
      repeat (2 * FRAME_CLK + 5) @(posedge clk);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
